decoder_stage_riscv: RTL and testbench
======================================

# decoder_stage_riscv

Registered, buffered instruction-decode stage for the RV32I core; the successor to the purely combinational decoder. It accepts fetched instructions with their PC over a valid/ready handshake and holds them in a DEPTH-entry queue. It decodes the queue head into a registered control bundle for the execute stage. It adds flush support, optional RV32M decode and a saturating illegal-instruction counter.

## Interface
- DEPTH, 2, queue entries; power of two, ≥ 2
- CNT_W, 16, width of illegal-instruction counter
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  drop all queued and registered instructions
- instr_valid_i  in  1  fetch offers instruction
- instr_ready_o  out  1  stage can accept
- instr_i  in  32  fetched instruction
- pc_i  in  32  PC of instr_i
- dec_valid_o  out  1  decoded bundle valid
- dec_ready_i  in  1  execute accepts bundle
- dec_pc_o / dec_instr_o  out  32 / 32  pass-through PC and instruction
- ex_op_a_sel_o  out  2  operand A select
- ex_op_b_sel_o  out  3  operand B select
- alu_op_o  out  5  ALU operation
- mem_req_o, mem_we_o  out  1, 1  LSU request and write
- mem_size_o  out  3  LSU size (funct3 encoding)
- gpr_we_a_o, wb_src_sel_o  out  1, 1  register write and writeback source
- illegal_instr_o, branch_o, jal_o, jalr_o  out  1 each  decode flags
- illegal_cnt_o  out  CNT_W  illegal instructions delivered

## Operation
- Queue: circular buffer of {pc, instr}, with write and read pointers of log2(DEPTH) bits that wrap naturally, plus a count of log2(DEPTH)+1 bits.
- instr_ready_o = (count != DEPTH) && !flush_i. A push occurs on instr_valid_i && instr_ready_o.
- Output register: loads the decoded head when the queue is non-empty and the output register is free: (!dec_valid_o || dec_ready_i). That load pops the queue.
- A push and a pop in the same cycle leave count unchanged. A push into an empty queue is not bypassed.
- Decode rules are the team's standard RV32I mapping:
  - LOAD, STORE, OP_IMM, OP, LUI, AUIPC, BRANCH, JAL, JALR, MISC_MEM, SYSTEM.
  - Invalid funct3/funct7 combinations set illegal_instr_o. Illegal loads and stores force mem_size_o = LDST_B.
  - Illegal branches force alu_op_o = ALU_EQ.
  - ECALL/EBREAK are flagged illegal (trap path).
  - Any other opcode, including a low opcode bits value other than 2'b11, gives the default illegal bundle.
- Illegal-bundle fields, decided:
  - mem_req_o = 0, mem_we_o = 0, gpr_we_a_o = 0, branch_o = 0, jal_o = 0, jalr_o = 0.
  - alu_op_o = ALU_ADD, ex_op_a_sel_o = OP_A_CURR_PC, ex_op_b_sel_o = OP_B_IMM_U.
- illegal_cnt_o increments on each output handshake (dec_valid_o && dec_ready_i && illegal_instr_o). It saturates at all-ones.
- Flush, on the edge where flush_i = 1:
  - Pointers and count go to 0 and dec_valid_o goes to 0.
  - A push in that cycle is impossible, because ready is forced low.
  - An output handshake in that same cycle still counts toward illegal_cnt_o.
  - illegal_cnt_o is not cleared.
- Reset (asynchronous, any time, including mid-transfer):
  - Pointers, count, dec_valid_o and illegal_cnt_o go to 0.
  - All bundle outputs take the illegal-bundle values with illegal_instr_o = 0.
  - dec_pc_o and dec_instr_o go to 0.

## Timing
- Latency: an instruction accepted at edge E0 appears with dec_valid_o = 1 after edge E1, provided the output register is free.
- Throughput: one instruction per cycle when dec_ready_i is held at 1.
- Once dec_valid_o = 1, all outputs stay stable until a handshake or a flush.
- instr_ready_o depends only on registered count and flush_i. It has no combinational path from dec_ready_i.
- Backpressure: with dec_ready_i = 0, the queue fills. instr_ready_o drops after DEPTH pushes plus one instruction held in the output register.

## Configuration
- DECODER_RV32M_EN defined: OP with funct7 = 7'b0000001 is legal and gives alu_op_o = {2'b10, funct3}, i.e. MUL..REMU.
- DECODER_RV32M_EN not defined: that encoding sets illegal_instr_o = 1 and returns the default illegal bundle.

## Structure
- Package riscv_pkg holds:
  - opcode constants;
  - ALU_* codes, including the M-extension codes 5'b10xxx;
  - OP_A_* / OP_B_* selectors, WB_* selectors and LDST_* sizes;
  - a packed struct decode_bundle_t.
- Sub-module decoder_core_riscv: purely combinational, 32-bit instruction in, decode_bundle_t out. It is instantiated once on the queue head.

## Test plan
- Reset, then push addi x1,x0,5 (0x00500093) at PC 0x100 with dec_ready_i = 1 -> dec_valid_o after E1 with:
  - alu_op_o = ALU_ADD, ex_op_b_sel_o = OP_B_IMM_I, gpr_we_a_o = 1;
  - dec_pc_o = 0x100.
- dec_ready_i = 0 with DEPTH = 2 and 4 pushes offered -> 3 accepted, instr_ready_o = 0. Then release dec_ready_i -> the 3 are delivered in order on 3 consecutive cycles.
- Push 0xFFFFFFFF and ECALL (0x00000073), both accepted -> both show illegal_instr_o = 1, mem_req_o = 0, and illegal_cnt_o = 2.
- Fill the queue, then assert flush_i for one cycle while instr_valid_i = 1 -> next cycle count = 0 and dec_valid_o = 0; the offered instruction is not accepted.
- MUL x3,x1,x2 (0x022081B3) -> with DECODER_RV32M_EN, alu_op_o = 5'b10000 and legal; without it, illegal_instr_o = 1.
- Force the counter to all-ones and deliver one more illegal instruction -> illegal_cnt_o stays at all-ones. Assert rst_ni low mid-stream -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/operand/writeback/LSU encodings,
// the registered decode bundle and the queue entry format.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0f;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6f;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_XOR    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_AND    = 5'd4;
  localparam logic [4:0] ALU_SLL    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_SLT    = 5'd8;
  localparam logic [4:0] ALU_SLTU   = 5'd9;
  localparam logic [4:0] ALU_EQ     = 5'd10;
  localparam logic [4:0] ALU_NE     = 5'd11;
  localparam logic [4:0] ALU_LT     = 5'd12;
  localparam logic [4:0] ALU_GE     = 5'd13;
  localparam logic [4:0] ALU_LTU    = 5'd14;
  localparam logic [4:0] ALU_GEU    = 5'd15;
  // M-extension codes are {2'b10, funct3}.
  localparam logic [4:0] ALU_MUL    = 5'b10000;
  localparam logic [4:0] ALU_MULH   = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV    = 5'b10100;
  localparam logic [4:0] ALU_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_REM    = 5'b10110;
  localparam logic [4:0] ALU_REMU   = 5'b10111;

  localparam logic [1:0] OP_A_REG_A   = 2'd0;
  localparam logic [1:0] OP_A_CURR_PC = 2'd1;
  localparam logic [1:0] OP_A_ZERO    = 2'd2;

  localparam logic [2:0] OP_B_REG_B   = 3'd0;
  localparam logic [2:0] OP_B_IMM_I   = 3'd1;
  localparam logic [2:0] OP_B_IMM_S   = 3'd2;
  localparam logic [2:0] OP_B_IMM_B   = 3'd3;
  localparam logic [2:0] OP_B_IMM_U   = 3'd4;
  localparam logic [2:0] OP_B_IMM_J   = 3'd5;
  localparam logic [2:0] OP_B_INCR_PC = 3'd6;

  localparam logic WB_ALU = 1'b0;
  localparam logic WB_LSU = 1'b1;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef struct packed {
    logic [1:0] op_a_sel;
    logic [2:0] op_b_sel;
    logic [4:0] alu_op;
    logic       mem_req;
    logic       mem_we;
    logic [2:0] mem_size;
    logic       gpr_we;
    logic       wb_src_sel;
    logic       illegal;
    logic       branch;
    logic       jal;
    logic       jalr;
  } decode_bundle_t;

  localparam decode_bundle_t ILLEGAL_BUNDLE = '{
    op_a_sel: OP_A_CURR_PC, op_b_sel: OP_B_IMM_U, alu_op: ALU_ADD,
    mem_req: 1'b0, mem_we: 1'b0, mem_size: LDST_B, gpr_we: 1'b0,
    wb_src_sel: WB_ALU, illegal: 1'b1, branch: 1'b0, jal: 1'b0, jalr: 1'b0};

  localparam decode_bundle_t RESET_BUNDLE = '{
    op_a_sel: OP_A_CURR_PC, op_b_sel: OP_B_IMM_U, alu_op: ALU_ADD,
    mem_req: 1'b0, mem_we: 1'b0, mem_size: LDST_B, gpr_we: 1'b0,
    wb_src_sel: WB_ALU, illegal: 1'b0, branch: 1'b0, jal: 1'b0, jalr: 1'b0};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Integer ALU op for OP / OP_IMM; alt selects SUB/SRA (instr[30]).
  function automatic logic [4:0] alu_arith(input logic [2:0] funct3, input logic alt);
    logic [4:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decoder_core_riscv.sv
// Combinational RV32I decoder: instruction word in, decode_bundle_t out.
// Define DECODER_RV32M_EN to accept the RV32M encodings of OP.
module decoder_core_riscv
  import riscv_pkg::*;
(
  input  logic [31:0]    instr_i,
  output decode_bundle_t bundle_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       rsvd_zero;

  assign opcode    = instr_i[6:0];
  assign funct3    = instr_i[14:12];
  assign funct7    = instr_i[31:25];
  // FENCE.I is only accepted with its imm/rs1/rd fields zero.
  assign rsvd_zero = (instr_i[31:15] == '0) && (instr_i[11:7] == '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bundle_o = ILLEGAL_BUNDLE;
    case (opcode)
      OPC_LOAD: begin
        if (funct3 inside {LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU}) begin
          bundle_o.illegal    = 1'b0;
          bundle_o.op_a_sel   = OP_A_REG_A;
          bundle_o.op_b_sel   = OP_B_IMM_I;
          bundle_o.mem_req    = 1'b1;
          bundle_o.mem_size   = funct3;
          bundle_o.gpr_we     = 1'b1;
          bundle_o.wb_src_sel = WB_LSU;
        end
      end
      OPC_STORE: begin
        if (funct3 inside {LDST_B, LDST_H, LDST_W}) begin
          bundle_o.illegal  = 1'b0;
          bundle_o.op_a_sel = OP_A_REG_A;
          bundle_o.op_b_sel = OP_B_IMM_S;
          bundle_o.mem_req  = 1'b1;
          bundle_o.mem_we   = 1'b1;
          bundle_o.mem_size = funct3;
        end
      end
      OPC_OP_IMM: begin
        if ((funct3 != 3'b001 && funct3 != 3'b101) ||
            (funct3 == 3'b001 && funct7 == 7'b0000000) ||
            (funct3 == 3'b101 && (funct7 == 7'b0000000 || funct7 == 7'b0100000))) begin
          bundle_o.illegal  = 1'b0;
          bundle_o.op_a_sel = OP_A_REG_A;
          bundle_o.op_b_sel = OP_B_IMM_I;
          bundle_o.alu_op   = alu_arith(funct3, (funct3 == 3'b101) && funct7[5]);
          bundle_o.gpr_we   = 1'b1;
        end
      end
      OPC_OP: begin
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          bundle_o.illegal  = 1'b0;
          bundle_o.op_a_sel = OP_A_REG_A;
          bundle_o.op_b_sel = OP_B_REG_B;
          bundle_o.alu_op   = alu_arith(funct3, funct7[5]);
          bundle_o.gpr_we   = 1'b1;
        end
`ifdef DECODER_RV32M_EN
        else if (funct7 == 7'b0000001) begin
          bundle_o.illegal  = 1'b0;
          bundle_o.op_a_sel = OP_A_REG_A;
          bundle_o.op_b_sel = OP_B_REG_B;
          bundle_o.alu_op   = {2'b10, funct3};
          bundle_o.gpr_we   = 1'b1;
        end
`endif
      end
      OPC_LUI: begin
        bundle_o.illegal  = 1'b0;
        bundle_o.op_a_sel = OP_A_ZERO;
        bundle_o.gpr_we   = 1'b1;
      end
      OPC_AUIPC: begin
        bundle_o.illegal = 1'b0;
        bundle_o.gpr_we  = 1'b1;
      end
      OPC_BRANCH: begin
        bundle_o.alu_op = ALU_EQ;
        if (funct3 != 3'b010 && funct3 != 3'b011) begin
          bundle_o.illegal  = 1'b0;
          bundle_o.op_a_sel = OP_A_REG_A;
          bundle_o.op_b_sel = OP_B_REG_B;
          bundle_o.branch   = 1'b1;
          case (funct3)
            3'b000:  bundle_o.alu_op = ALU_EQ;
            3'b001:  bundle_o.alu_op = ALU_NE;
            3'b100:  bundle_o.alu_op = ALU_LT;
            3'b101:  bundle_o.alu_op = ALU_GE;
            3'b110:  bundle_o.alu_op = ALU_LTU;
            default: bundle_o.alu_op = ALU_GEU;
          endcase
        end
      end
      OPC_JAL: begin
        bundle_o.illegal  = 1'b0;
        bundle_o.op_b_sel = OP_B_INCR_PC;
        bundle_o.gpr_we   = 1'b1;
        bundle_o.jal      = 1'b1;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          bundle_o.illegal  = 1'b0;
          bundle_o.op_b_sel = OP_B_INCR_PC;
          bundle_o.gpr_we   = 1'b1;
          bundle_o.jalr     = 1'b1;
        end
      end
      OPC_MISC_MEM: begin
        if (funct3 == 3'b000 || (funct3 == 3'b001 && rsvd_zero)) begin
          bundle_o.illegal  = 1'b0;
          bundle_o.op_a_sel = OP_A_REG_A;
          bundle_o.op_b_sel = OP_B_IMM_I;
        end
      end
      // SYSTEM (ECALL/EBREAK, and CSR ops which this core lacks) takes the trap path.
      OPC_SYSTEM: bundle_o = ILLEGAL_BUNDLE;
      default:    bundle_o = ILLEGAL_BUNDLE;
    endcase
  end

endmodule

// File: rtl/decoder_stage_riscv.sv
// Buffered RV32I decode stage: DEPTH-entry fetch queue, registered decode bundle,
// flush and saturating illegal counter. RV32M decode via DECODER_RV32M_EN.
module decoder_stage_riscv
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      pc_i,
  output logic             dec_valid_o,
  input  logic             dec_ready_i,
  output logic [31:0]      dec_pc_o,
  output logic [31:0]      dec_instr_o,
  output logic [1:0]       ex_op_a_sel_o,
  output logic [2:0]       ex_op_b_sel_o,
  output logic [4:0]       alu_op_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [2:0]       mem_size_o,
  output logic             gpr_we_a_o,
  output logic             wb_src_sel_o,
  output logic             illegal_instr_o,
  output logic             branch_o,
  output logic             jal_o,
  output logic             jalr_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL    = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  fetch_entry_t     head;
  decode_bundle_t   head_bundle, bundle_q;
  logic             dec_valid_q;
  logic [31:0]      pc_q, instr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push, pop, out_hs;

  assign instr_ready_o = (count != FULL) && !flush_i;
  assign push          = instr_valid_i && instr_ready_o;
  assign pop           = (count != '0) && (!dec_valid_q || dec_ready_i);
  assign out_hs        = dec_valid_q && dec_ready_i;
  assign head          = mem[rd_ptr];

  // NOTE: queue storage has no reset; count alone says which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{pc: pc_i, instr: instr_i};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  decoder_core_riscv u_core (
    .instr_i  (head.instr),
    .bundle_o (head_bundle)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_valid_q <= 1'b0;
      bundle_q    <= RESET_BUNDLE;
      pc_q        <= '0;
      instr_q     <= '0;
    end else if (flush_i) begin
      dec_valid_q <= 1'b0;
    end else if (pop) begin
      dec_valid_q <= 1'b1;
      bundle_q    <= head_bundle;
      pc_q        <= head.pc;
      instr_q     <= head.instr;
    end else if (out_hs) begin
      dec_valid_q <= 1'b0;
    end
  end

  // A handshake in a flush cycle still delivered its bundle, so it still counts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (out_hs && bundle_q.illegal && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign dec_valid_o     = dec_valid_q;
  assign dec_pc_o        = pc_q;
  assign dec_instr_o     = instr_q;
  assign ex_op_a_sel_o   = bundle_q.op_a_sel;
  assign ex_op_b_sel_o   = bundle_q.op_b_sel;
  assign alu_op_o        = bundle_q.alu_op;
  assign mem_req_o       = bundle_q.mem_req;
  assign mem_we_o        = bundle_q.mem_we;
  assign mem_size_o      = bundle_q.mem_size;
  assign gpr_we_a_o      = bundle_q.gpr_we;
  assign wb_src_sel_o    = bundle_q.wb_src_sel;
  assign illegal_instr_o = bundle_q.illegal;
  assign branch_o        = bundle_q.branch;
  assign jal_o           = bundle_q.jal;
  assign jalr_o          = bundle_q.jalr;
  assign illegal_cnt_o   = cnt_q;

endmodule

// File: tb/tb_decoder_stage_riscv.sv
// Self-checking bench for decoder_stage_riscv: directed steps plus random traffic
// against a queue-level reference model. Honours DECODER_RV32M_EN when defined.
module tb_decoder_stage_riscv;

  localparam int DEPTH   = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic flush_i = 1'b0, instr_valid_i = 1'b0, dec_ready_i = 1'b0;
  logic [31:0] instr_i = '0, pc_i = '0;
  logic instr_ready_o, dec_valid_o;
  logic [31:0] dec_pc_o, dec_instr_o;
  logic [1:0] ex_op_a_sel_o;
  logic [2:0] ex_op_b_sel_o, mem_size_o;
  logic [4:0] alu_op_o;
  logic mem_req_o, mem_we_o, gpr_we_a_o, wb_src_sel_o;
  logic illegal_instr_o, branch_o, jal_o, jalr_o;
  logic [CNT_W-1:0] illegal_cnt_o;

  always #5 clk = ~clk;

  decoder_stage_riscv #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_i(instr_i), .pc_i(pc_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .dec_pc_o(dec_pc_o), .dec_instr_o(dec_instr_o),
    .ex_op_a_sel_o(ex_op_a_sel_o), .ex_op_b_sel_o(ex_op_b_sel_o), .alu_op_o(alu_op_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_size_o(mem_size_o),
    .gpr_we_a_o(gpr_we_a_o), .wb_src_sel_o(wb_src_sel_o),
    .illegal_instr_o(illegal_instr_o), .branch_o(branch_o), .jal_o(jal_o), .jalr_o(jalr_o),
    .illegal_cnt_o(illegal_cnt_o)
  );

  // Expected decode, computed straight from the instruction encoding rules.
  typedef struct {
    logic [1:0] a; logic [2:0] b; logic [4:0] alu;
    logic req, we; logic [2:0] size; logic gwe, wb, ill, br, jal, jalr;
  } exp_t;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  int   n_tests = 0, n_fail = 0;
  ent_t m_fifo[$];
  ent_t m_out;
  bit   m_valid;
  int   m_cnt;
  bit   last_push;

  function automatic logic [4:0] arith_code(input logic [2:0] f3);
    case (f3)
      3'd0: return 5'd0;   // add
      3'd1: return 5'd5;   // sll
      3'd2: return 5'd8;   // slt
      3'd3: return 5'd9;   // sltu
      3'd4: return 5'd2;   // xor
      3'd5: return 5'd6;   // srl
      3'd6: return 5'd3;   // or
      default: return 5'd4; // and
    endcase
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok;
    f3 = ins[14:12];
    f7 = ins[31:25];
    e = '{a: 2'd1, b: 3'd4, alu: 5'd0, req: 1'b0, we: 1'b0, size: 3'd0,
          gwe: 1'b0, wb: 1'b0, ill: 1'b1, br: 1'b0, jal: 1'b0, jalr: 1'b0};
    case (ins[6:0])
      7'h03: if (f3 != 3 && f3 != 6 && f3 != 7) begin
        e.ill = 0; e.a = 0; e.b = 1; e.req = 1; e.size = f3; e.gwe = 1; e.wb = 1;
      end
      7'h23: if (f3 <= 2) begin
        e.ill = 0; e.a = 0; e.b = 2; e.req = 1; e.we = 1; e.size = f3;
      end
      7'h13: begin
        ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
        if (ok) begin
          e.ill = 0; e.a = 0; e.b = 1; e.gwe = 1;
          e.alu = (f3 == 5 && f7 == 7'h20) ? 5'd7 : arith_code(f3);
        end
      end
      7'h33: begin
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
`ifdef DECODER_RV32M_EN
        ok = ok || (f7 == 7'h01);
`endif
        if (ok) begin
          e.ill = 0; e.a = 0; e.b = 0; e.gwe = 1;
          if (f7 == 7'h01)      e.alu = 5'd16 + 5'(f3);
          else if (f7 == 7'h20) e.alu = (f3 == 0) ? 5'd1 : 5'd7;
          else                  e.alu = arith_code(f3);
        end
      end
      7'h37: begin e.ill = 0; e.a = 2; e.gwe = 1; end
      7'h17: begin e.ill = 0; e.gwe = 1; end
      7'h63: begin
        e.alu = 5'd10;
        if (f3 != 2 && f3 != 3) begin
          e.ill = 0; e.a = 0; e.b = 0; e.br = 1;
          e.alu = (f3 >= 4) ? 5'(f3) + 5'd8 : 5'(f3) + 5'd10;
        end
      end
      7'h6f: begin e.ill = 0; e.b = 6; e.gwe = 1; e.jal = 1; end
      7'h67: if (f3 == 0) begin e.ill = 0; e.b = 6; e.gwe = 1; e.jalr = 1; end
      7'h0f: if (f3 == 0 || (f3 == 1 && ins[31:15] == 0 && ins[11:7] == 0)) begin
        e.ill = 0; e.a = 0; e.b = 1;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0] opc;
    r = $urandom;
    case ($urandom_range(0, 13))
      0: opc = 7'h03;  1: opc = 7'h23;  2: opc = 7'h13;  3: opc = 7'h33;
      4: opc = 7'h37;  5: opc = 7'h17;  6: opc = 7'h63;  7: opc = 7'h6f;
      8: opc = 7'h67;  9: opc = 7'h0f;  10: opc = 7'h73; 11: opc = 7'h33;
      12: opc = {r[6:2], 2'b01};
      default: opc = 7'h7b;
    endcase
    r[6:0] = opc;
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(0, 4) == 0) begin r[31:15] = '0; r[11:7] = '0; end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    check("instr_ready", 32'(instr_ready_o), 32'((m_fifo.size() != DEPTH) && !flush_i));
    check("dec_valid", 32'(dec_valid_o), 32'(m_valid));
    check("illegal_cnt", 32'(illegal_cnt_o), 32'(m_cnt));
    if (m_valid) begin
      e = ref_decode(m_out.instr);
      check("dec_pc", dec_pc_o, m_out.pc);
      check("dec_instr", dec_instr_o, m_out.instr);
      check("op_a_sel", 32'(ex_op_a_sel_o), 32'(e.a));
      check("op_b_sel", 32'(ex_op_b_sel_o), 32'(e.b));
      check("alu_op", 32'(alu_op_o), 32'(e.alu));
      check("mem_req", 32'(mem_req_o), 32'(e.req));
      check("mem_we", 32'(mem_we_o), 32'(e.we));
      check("mem_size", 32'(mem_size_o), 32'(e.size));
      check("gpr_we", 32'(gpr_we_a_o), 32'(e.gwe));
      check("wb_src", 32'(wb_src_sel_o), 32'(e.wb));
      check("illegal", 32'(illegal_instr_o), 32'(e.ill));
      check("branch", 32'(branch_o), 32'(e.br));
      check("jal", 32'(jal_o), 32'(e.jal));
      check("jalr", 32'(jalr_o), 32'(e.jalr));
    end
  endtask

  task automatic model_step();
    bit push, pop, hs;
    push = instr_valid_i && (m_fifo.size() != DEPTH) && !flush_i;
    hs   = m_valid && dec_ready_i;
    pop  = (m_fifo.size() != 0) && (!m_valid || dec_ready_i);
    if (hs && ref_decode(m_out.instr).ill && m_cnt < CNT_MAX) m_cnt++;
    if (flush_i) begin
      m_fifo.delete();
      m_valid = 0;
    end else begin
      if (pop) begin
        m_out = m_fifo.pop_front();
        m_valid = 1;
      end else if (hs) begin
        m_valid = 0;
      end
      if (push) m_fifo.push_back('{pc: pc_i, instr: instr_i});
    end
    last_push = push;
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_valid = 0;
    m_cnt = 0;
  endtask

  // One clock: drive inputs after the falling edge, check, then advance the model.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    @(negedge clk);
    instr_valid_i = v; instr_i = ins; pc_i = pc; dec_ready_i = rdy; flush_i = fl;
    #1;
    check_outputs();
    model_step();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 32'(instr_ready_o), 32'd1);
    check({tag, "_valid"}, 32'(dec_valid_o), 32'd0);
    check({tag, "_cnt"}, 32'(illegal_cnt_o), 32'd0);
    check({tag, "_pc"}, dec_pc_o, 32'd0);
    check({tag, "_instr"}, dec_instr_o, 32'd0);
    check({tag, "_opa"}, 32'(ex_op_a_sel_o), 32'd1);
    check({tag, "_opb"}, 32'(ex_op_b_sel_o), 32'd4);
    check({tag, "_alu"}, 32'(alu_op_o), 32'd0);
    check({tag, "_flags"},
          32'({mem_req_o, mem_we_o, gpr_we_a_o, wb_src_sel_o,
               illegal_instr_o, branch_o, jal_o, jalr_o}), 32'd0);
    check({tag, "_size"}, 32'(mem_size_o), 32'd0);
  endtask

  initial begin
    int accepted;
    // Power-on reset held across a clock edge.
    @(negedge clk);
    #1;
    check_reset("por");
    rst_ni = 1'b1;
    model_reset();

    // addi x1,x0,5 at 0x100: visible after the second edge.
    cycle(1, 32'h00500093, 32'h100, 1, 0);
    cycle(0, 32'h0, 32'h0, 1, 0);
    check("addi_latency_not_yet", 32'(dec_valid_o), 32'd0);
    cycle(0, 32'h0, 32'h0, 1, 0);
    check("addi_valid", 32'(dec_valid_o), 32'd1);
    check("addi_alu", 32'(alu_op_o), 32'd0);
    check("addi_opb", 32'(ex_op_b_sel_o), 32'd1);
    check("addi_gwe", 32'(gpr_we_a_o), 32'd1);
    check("addi_pc", dec_pc_o, 32'h100);
    cycle(0, 32'h0, 32'h0, 1, 0);

    // Backpressure: 4 offered, DEPTH + 1 accepted, then in-order drain.
    accepted = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 32'h00100093 + (32'(i) << 20), 32'h200 + 32'(4 * i), 0, 0);
      accepted += int'(last_push);
    end
    check("bp_accepted", 32'(accepted), 32'd3);
    cycle(0, 32'h0, 32'h0, 1, 0);
    check("bp_ready_low", 32'(instr_ready_o), 32'd0);
    check("bp_first", dec_pc_o, 32'h200);
    for (int i = 1; i < 3; i++) begin
      cycle(0, 32'h0, 32'h0, 1, 0);
      check("bp_valid", 32'(dec_valid_o), 32'd1);
      check("bp_order", dec_pc_o, 32'h200 + 32'(4 * i));
    end
    cycle(0, 32'h0, 32'h0, 1, 0);
    check("bp_drained", 32'(dec_valid_o), 32'd0);

    // Two illegal instructions: all-ones word and ECALL.
    cycle(1, 32'hFFFFFFFF, 32'h300, 1, 0);
    cycle(1, 32'h00000073, 32'h304, 1, 0);
    cycle(0, 32'h0, 32'h0, 1, 0);
    check("ill_ff_flag", 32'(illegal_instr_o), 32'd1);
    check("ill_ff_memreq", 32'(mem_req_o), 32'd0);
    cycle(0, 32'h0, 32'h0, 1, 0);
    check("ill_ecall_flag", 32'(illegal_instr_o), 32'd1);
    check("ill_ecall_memreq", 32'(mem_req_o), 32'd0);
    cycle(0, 32'h0, 32'h0, 1, 0);
    check("ill_cnt_two", 32'(illegal_cnt_o), 32'd2);

    // Flush a full stage while fetch is still offering.
    for (int i = 0; i < 3; i++) cycle(1, 32'h00000013, 32'h400 + 32'(4 * i), 0, 0);
    cycle(1, 32'h00000013, 32'h40C, 0, 1);
    check("flush_ready_low", 32'(instr_ready_o), 32'd0);
    cycle(0, 32'h0, 32'h0, 0, 0);
    check("flush_valid_clr", 32'(dec_valid_o), 32'd0);
    check("flush_ready_back", 32'(instr_ready_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 32'h0, 32'h0, 1, 0);
      check("flush_empty", 32'(dec_valid_o), 32'd0);
    end

    // mul x3,x1,x2
    cycle(1, 32'h022081B3, 32'h500, 1, 0);
    cycle(0, 32'h0, 32'h0, 1, 0);
    cycle(0, 32'h0, 32'h0, 1, 0);
`ifdef DECODER_RV32M_EN
    check("mul_alu", 32'(alu_op_o), 32'h10);
    check("mul_legal", 32'(illegal_instr_o), 32'd0);
`else
    check("mul_illegal", 32'(illegal_instr_o), 32'd1);
`endif
    cycle(0, 32'h0, 32'h0, 1, 0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      cycle(logic'($urandom_range(0, 9) < 6), rand_instr(), $urandom & 32'hFFFF_FFFC,
            logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 24) == 0));
    end
    for (int i = 0; i < 4; i++) cycle(0, 32'h0, 32'h0, 1, 0);

    // Saturate the counter, then keep delivering illegal instructions.
    for (int i = 0; i < CNT_MAX + 5; i++) cycle(1, 32'hFFFFFFFF, 32'h600, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 32'h0, 32'h0, 1, 0);
    check("cnt_saturated", 32'(illegal_cnt_o), 32'(CNT_MAX));

    // Asynchronous reset between clock edges with work in flight.
    cycle(1, 32'h00500093, 32'h700, 0, 0);
    cycle(1, 32'h00a00093, 32'h704, 0, 0);
    #6;
    instr_valid_i = 0;
    rst_ni = 1'b0;
    #1;
    check_reset("rst_mid");
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1, 32'h00000013, 32'h800 + 32'(4 * i), 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 32'h0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
